// File: rtl/cbus_rr_arbiter_if.sv
// cbus_rr_arbiter_if: cbus request/response types and the arbiter's bus bundle
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

interface cbus_rr_arbiter_if #(parameter int NUM_INPUTS = 2);
  import cbus_pkg::*;
  cbus_req_t  [NUM_INPUTS-1:0] ireqs;
  cbus_resp_t [NUM_INPUTS-1:0] iresps;
  cbus_req_t                   oreq;
  cbus_resp_t                  oresp;
  modport master (output ireqs, oresp, input iresps, oreq);
  modport slave (input ireqs, oresp, output iresps, oreq);
endinterface

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin cbus arbiter, grant locked until ready && last
// Optional transaction watchdog enabled by CBUS_ARB_TIMEOUT_EN.
module cbus_rr_arbiter #(
  parameter int NUM_INPUTS = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  cbus_rr_arbiter_if.slave              bus,
  output logic                          busy,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
  output logic                          timeout
);
  localparam int IDX_W = $clog2(NUM_INPUTS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, sel_q, win;
  logic found, grant, done;
  always_comb begin
    found = 1'b0;
    win = ptr_q;
    // descending scan so the closest index to ptr wins
    for (int k = NUM_INPUTS - 1; k >= 0; k--)
      if (bus.ireqs[IDX_W'((int'(ptr_q) + k) % NUM_INPUTS)].valid) begin
        found = 1'b1;
        win = IDX_W'((int'(ptr_q) + k) % NUM_INPUTS);
      end
  end
  assign done = bus.oresp.ready && bus.oresp.last;
  assign grant = state_q == IDLE && found;
  assign busy = state_q == BUSY;
  always_comb begin
    state_d = state_q == IDLE ? (found ? BUSY : IDLE) : (done ? IDLE : BUSY);
    bus.oreq = '0;
    bus.iresps = '0;
    if (state_q == BUSY) begin
      bus.oreq = bus.ireqs[sel_q];
      bus.iresps[sel_q] = bus.oresp;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
      grant_idx <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        sel_q <= win;
        grant_idx <= win;
      end
      if (state_q == BUSY && done) ptr_q <= sel_q == IDX_W'(NUM_INPUTS - 1) ? '0 : sel_q + 1'b1;
    end
`ifdef CBUS_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wait_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (grant) wait_cnt <= '0;
      else if (busy && !done && wait_cnt != 32'(TIMEOUT_CYCLES)) wait_cnt <= wait_cnt + 1'b1;
      if (busy && !done && wait_cnt == 32'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end
`else
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: scoreboard bench for the round-robin cbus arbiter (4 requesters)
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;
`ifdef CBUS_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, busy, timeout;
  logic [1:0] grant_idx;
  int n_cmp = 0, n_bad = 0, seq = 0, cur = 0;
  int exp_q[$];
  logic busy_d = 1'b0;
  cbus_resp_t [3:0] er;
  cbus_req_t eq;
  cbus_rr_arbiter_if #(.NUM_INPUTS(4)) bus ();
  cbus_rr_arbiter #(.NUM_INPUTS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant_idx(grant_idx), .timeout(timeout)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // monitor: pops the expected winner at each new grant, checks routing every cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && !busy_d) begin
        if (exp_q.size() == 0) chk("unexpected_grant", 256'(grant_idx), 256'hff);
        else begin
          cur = exp_q.pop_front();
          chk("grant_idx", 256'(grant_idx), 256'(cur));
        end
      end
      er = '0;
      eq = '0;
      if (busy) begin
        er[cur] = bus.oresp;
        eq = bus.ireqs[cur];
      end
      chk("oreq", 256'(bus.oreq), 256'(eq));
      chk("iresps", 256'(bus.iresps), 256'(er));
    end
    busy_d = busy;
  end

  task automatic raise(input int i, input logic [3:0] len);
    bus.ireqs[i].valid = 1'b1;
    bus.ireqs[i].write = i[0];
    bus.ireqs[i].addr = 32'h100 * (i + 1) + seq;
    bus.ireqs[i].wdata = $urandom;
    bus.ireqs[i].len = len;
    seq++;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_busy", 256'(busy), 256'(1));
  endtask

  task automatic txn(input int who, input int beats, input bit keep);
    wait_busy();
    for (int b = 0; b < beats; b++) begin
      bus.oresp.ready = 1'b1;
      bus.oresp.last = b == beats - 1;
      bus.oresp.data = $urandom;
      @(posedge clk);
      #1;
    end
    bus.oresp = '0;
    if (!keep) bus.ireqs[who].valid = 1'b0;
    chk("busy_released", 256'(busy), 256'(0));
    chk("grant_hold", 256'(grant_idx), 256'(who));
  endtask

  initial begin
    bus.ireqs = '0;
    bus.oresp = '0;
    @(posedge clk);
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_grant_idx", 256'(grant_idx), 256'(0));
    chk("rst_oreq", 256'(bus.oreq), 256'(0));
    chk("rst_iresps", 256'(bus.iresps), 256'(0));
    chk("rst_timeout", 256'(timeout), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    // single request: no combinational forwarding, visible one edge later
    exp_q.push_back(1);
    raise(1, 1);
    #3;
    chk("no_comb_fwd", 256'(bus.oreq.valid), 256'(0));
    @(posedge clk);
    #1;
    chk("latency_busy", 256'(busy), 256'(1));
    chk("latency_valid", 256'(bus.oreq.valid), 256'(1));
    @(posedge clk);
    #1;
    txn(1, 1, 0);
    // ptr=2: requesters 3 and 1 -> 3 then wrap to 1
    exp_q.push_back(3);
    exp_q.push_back(1);
    raise(3, 1);
    raise(1, 1);
    txn(3, 1, 0);
    txn(1, 1, 0);
    // ptr=2: contention between 0 and 1 alternates
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    raise(0, 1);
    raise(1, 1);
    txn(0, 1, 1);
    txn(1, 1, 1);
    txn(0, 1, 0);
    txn(1, 1, 0);
    // ptr=2: 4-beat burst from 2 holds the grant while 3 waits
    exp_q.push_back(2);
    exp_q.push_back(3);
    raise(2, 4);
    raise(3, 1);
    txn(2, 4, 0);
    txn(3, 1, 0);
    // ptr=0: all four continuously valid, two full rounds
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) exp_q.push_back(i);
    for (int i = 0; i < 4; i++) raise(i, 1);
    for (int i = 0; i < 4; i++) txn(i, 1, 1);
    for (int i = 0; i < 4; i++) txn(i, 1, 0);
    // ptr=0: stall with ready=0 to exercise the watchdog
    exp_q.push_back(0);
    raise(0, 1);
    @(posedge clk);
    #1;
    chk("to_busy", 256'(busy), 256'(1));
    repeat (7) @(posedge clk);
    #1;
    chk("timeout_pre", 256'(timeout), 256'(0));
    @(posedge clk);
    #1;
    chk("timeout_8th", 256'(timeout), 256'(TO));
    txn(0, 1, 0);
    chk("timeout_sticky", 256'(timeout), 256'(TO));
    // ptr=1: reset mid-burst from requester 2
    exp_q.push_back(2);
    raise(2, 4);
    raise(0, 1);
    wait_busy();
    bus.oresp.ready = 1'b1;
    bus.oresp.last = 1'b0;
    bus.oresp.data = 32'hdead_beef;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_oreq_valid", 256'(bus.oreq.valid), 256'(0));
    chk("arst_busy", 256'(busy), 256'(0));
    chk("arst_iresps", 256'(bus.iresps), 256'(0));
    chk("arst_grant_idx", 256'(grant_idx), 256'(0));
    bus.oresp = '0;
    exp_q.push_back(0);
    exp_q.push_back(2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    txn(0, 1, 0);
    txn(2, 1, 0);
    chk("timeout_after_reset", 256'(timeout), 256'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
